v_mul_seq: RTL
==============

V_MUL_SEQ -- requirements
Module: v_mul_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1, meaning the multiplier's cycles from operands applied to result valid.
REQ-002 SHALL have parameter VLEN, default 512, meaning the vector register width in bits (words per register NW = VLEN/32 = 16).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a vector multiply; sampled only in IDLE.
REQ-006 vl  in  7  element count.
REQ-007 sew  in  3  element width code: 000=8b, 001=16b, 010=32b.
REQ-008 vs1, vs2, vd  in  5 each  source and destination vector register indices.
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  illegal sew, valid with done.
REQ-012 rf_rd_en  out  1, rf_rd_word  out  4, rf_rd_vreg_a / rf_rd_vreg_b  out  5 each  register-file read request.
REQ-013 rf_rd_data_a / rf_rd_data_b  in  32 each  read data, valid the cycle after rf_rd_en.
REQ-014 mul_op_A / mul_op_B  out  32, mul_sew  out  3, mul_is_mul  out  1  packed multiplier operands.
REQ-015 mul_result  in  32  packed low-half products, valid MUL_LAT cycles after operands.
REQ-016 rf_wr_en  out  1, rf_wr_vreg  out  5, rf_wr_word  out  4, rf_wr_be  out  4, rf_wr_data  out  32  writeback port.

Function
REQ-017 SHALL latch vl, sew, vs1, vs2 and vd on an accepted start (start=1 in IDLE); start while busy is ignored.
REQ-018 Elements per word (EPW) SHALL be 4, 2 or 1 for sew 000, 001, 010; effective vl SHALL be min(vl, NW*EPW); word count NWD = ceil(vl_eff/EPW).
REQ-019 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on accepted start with legal sew and vl>0; ISSUE->DRAIN after word NWD-1 issues; DRAIN->IDLE when the pipeline is empty.
REQ-020 In ISSUE: one rf_rd_en per cycle, rf_rd_word counting 0..NWD-1, first read in the cycle after start is accepted.
REQ-021 mul_op_A/B SHALL be rf_rd_data_a/b combinationally, mul_sew the latched sew, mul_is_mul=1 while valid data is presented, else 0.
REQ-022 A valid/word/byte-enable pipeline of depth 1+MUL_LAT SHALL track each read; rf_wr_en for a word SHALL assert exactly 1+MUL_LAT cycles after its rf_rd_en, with rf_wr_data=mul_result and rf_wr_vreg=vd.
REQ-023 rf_wr_be SHALL be 4'b1111 except on the last word when vl_eff mod EPW = r != 0: the low r*(bytes per element) bytes set.
REQ-024 done SHALL pulse in the cycle after the last rf_wr_en; busy SHALL fall in that same cycle.
REQ-025 vl=0 with legal sew: no reads or writes; done pulses in the cycle after start; err=0.
REQ-026 sew > 010: no reads or writes; done and err pulse in the cycle after start.
REQ-027 Throughput SHALL be one word per cycle with no bubbles; ISSUE and DRAIN SHALL overlap with no idle cycle between them.

Reset
REQ-028 nrst low SHALL force IDLE, clear the pipeline, and drive busy, done, err, rf_rd_en, rf_wr_en, mul_is_mul to 0 and all other outputs to 0.
REQ-029 Reset asserted mid-operation SHALL abort without any further rf_wr_en; after release the block SHALL be in IDLE and accept start.

Structure
REQ-030 sew encodings, VLEN/NW constants and the state enum SHALL live in the shared vector package.
REQ-031 The tail byte-enable computation SHALL be a sub-module v_tail_be (inputs vl_eff, sew, is_last; output be[3:0]).

Verification
REQ-032 sew=000, vl=6, MUL_LAT=1, vs1 word0=0x0203FF05, vs2 word0=0x03040207 -> word0 written 0x060CFE23 with be=1111, word1 be=0011, rf_wr_en 2 cycles after each rf_rd_en.
REQ-033 sew=010, vl=16 -> 16 consecutive reads and 16 writes of words 0..15 with no gaps; done 1 cycle after the last write; busy high throughout.
REQ-034 sew=001, vl=40 -> clamped to 32: words 0..15 written, all be=1111.
REQ-035 vl=0 and, separately, sew=011 -> no rf_rd_en or rf_wr_en; done 1 cycle after start; err=0 and err=1 respectively.
REQ-036 start pulsed while busy, then nrst pulsed low after word 3 issues -> second start ignored; no writes after reset; a new start after release completes normally.

Source files
------------

// File: rtl/v_mul_seq_pkg.sv
// Shared vector definitions: element-width codes, register geometry and the
// sequencer state encoding.
// Pure declarations, no latency; no flow control.
package v_mul_seq_pkg;

  // Element width codes carried on sew.
  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;

  // Default vector register geometry: VLEN bits, NW 32-bit words.
  localparam int VLEN_DEF = 512;
  localparam int NW_DEF   = VLEN_DEF / 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic sew_legal(input logic [2:0] sew);
    return (sew <= SEW_32);
  endfunction

endpackage

// File: rtl/v_mul_seq_tail_be.sv
// Byte-enable for a writeback word: full word, or only the live low bytes of a
// partially filled last word.
// Combinational, zero latency; no flow control.
// Ports: vl_eff (clamped element count), sew (element width code),
//        is_last (word is the final one of the operation), be (byte enables).
module v_tail_be
  import v_mul_seq_pkg::*;
(
  input  logic [6:0] vl_eff,
  input  logic [2:0] sew,
  input  logic       is_last,
  output logic [3:0] be
);

  // nbytes = (elements left over in the last word) * (bytes per element)
  logic [2:0] nbytes;

  always_comb begin
    nbytes = 3'd0;
    case (sew)
      SEW_8:   nbytes = {1'b0, 2'(vl_eff % 7'd4)};
      SEW_16:  nbytes = {1'(vl_eff % 7'd2), 2'b00} >> 1;
      default: nbytes = 3'd0;
    endcase
    be = 4'b1111;
    if (is_last && (nbytes != 3'd0)) begin
      be = 4'((5'd1 << nbytes) - 5'd1);
    end
  end

endmodule

// File: rtl/v_mul_seq.sv
// Sequences a vector multiply: reads word pairs from the register file, feeds an
// external multiplier and writes back the packed low-half products.
// Latency: first read 1 cycle after start, each write 1+MUL_LAT cycles after its read,
// done 1 cycle after the last write; no backpressure, one word per cycle.
// Ports: start/vl/sew/vs1/vs2/vd request, busy/done/err status,
//        rf_rd_* read port, mul_* multiplier interface, rf_wr_* writeback port.
module v_mul_seq
  import v_mul_seq_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int VLEN    = VLEN_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [6:0]  vl,
  input  logic [2:0]  sew,
  input  logic [4:0]  vs1,
  input  logic [4:0]  vs2,
  input  logic [4:0]  vd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rf_rd_en,
  output logic [3:0]  rf_rd_word,
  output logic [4:0]  rf_rd_vreg_a,
  output logic [4:0]  rf_rd_vreg_b,
  input  logic [31:0] rf_rd_data_a,
  input  logic [31:0] rf_rd_data_b,
  output logic [31:0] mul_op_A,
  output logic [31:0] mul_op_B,
  output logic [2:0]  mul_sew,
  output logic        mul_is_mul,
  input  logic [31:0] mul_result,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_vreg,
  output logic [3:0]  rf_wr_word,
  output logic [3:0]  rf_wr_be,
  output logic [31:0] rf_wr_data
);

  localparam int NW    = VLEN / 32;
  localparam int PD    = 1 + MUL_LAT;  // read-data stage plus multiplier stages
  localparam int CAP8  = NW * 4;
  localparam int CAP16 = NW * 2;
  localparam int CAP32 = NW;

  state_e     state_q, state_d;
  logic [6:0] vl_eff_q, vl_eff_d;
  logic [4:0] nwd_q, nwd_d;
  logic [2:0] sew_q;
  logic [4:0] vs1_q, vs2_q, vd_q;
  logic [3:0] word_q;
  logic       done_q, err_q;

  logic [PD-1:0] p_vld;
  logic [PD-1:0] p_last;
  logic [3:0]    p_word [PD];
  logic [3:0]    p_be   [PD];

  logic       accept, go, issue_last, wr_last;
  logic [3:0] tail_be;

  assign accept = (state_q == ST_IDLE) && start;
  assign go     = accept && sew_legal(sew) && (vl != 7'd0);

  // Clamp the element count to what fits in one register, then count words.
  always_comb begin
    vl_eff_d = vl;
    nwd_d    = 5'd0;
    case (sew)
      SEW_8: begin
        if ({25'd0, vl} >= 32'(CAP8)) vl_eff_d = 7'(CAP8);
        nwd_d = 5'(({1'b0, vl_eff_d} + 8'd3) >> 2);
      end
      SEW_16: begin
        if ({25'd0, vl} >= 32'(CAP16)) vl_eff_d = 7'(CAP16);
        nwd_d = 5'(({1'b0, vl_eff_d} + 8'd1) >> 1);
      end
      default: begin
        if ({25'd0, vl} >= 32'(CAP32)) vl_eff_d = 7'(CAP32);
        nwd_d = 5'(vl_eff_d);
      end
    endcase
  end

  assign issue_last = (state_q == ST_ISSUE) && ({1'b0, word_q} == (nwd_q - 5'd1));
  assign wr_last    = p_vld[PD-1] && p_last[PD-1];

  v_tail_be u_tail_be (
    .vl_eff  (vl_eff_q),
    .sew     (sew_q),
    .is_last (issue_last),
    .be      (tail_be)
  );

  // DRAIN leaves on the last write itself so busy drops together with done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go)         state_d = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_last)    state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      vl_eff_q <= '0;
      nwd_q    <= '0;
      sew_q    <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vl_eff_q <= vl_eff_d;
        nwd_q    <= nwd_d;
        sew_q    <= sew;
        vs1_q    <= vs1;
        vs2_q    <= vs2;
        vd_q     <= vd;
      end
      if (go) begin
        word_q <= '0;
      end else if (state_q == ST_ISSUE) begin
        word_q <= word_q + 4'd1;
      end
      // Degenerate requests (illegal sew or vl=0) complete immediately.
      done_q <= (accept && !go) || wr_last;
      err_q  <= accept && !sew_legal(sew);
    end
  end

  // Per-word tracking pipeline, stage 0 aligned with the read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_vld  <= '0;
      p_last <= '0;
      for (int i = 0; i < PD; i++) begin
        p_word[i] <= '0;
        p_be[i]   <= '0;
      end
    end else begin
      p_vld[0]  <= (state_q == ST_ISSUE);
      p_last[0] <= issue_last;
      p_word[0] <= word_q;
      p_be[0]   <= tail_be;
      for (int i = 1; i < PD; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_last[i] <= p_last[i-1];
        p_word[i] <= p_word[i-1];
        p_be[i]   <= p_be[i-1];
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

  assign rf_rd_en     = (state_q == ST_ISSUE);
  assign rf_rd_word   = rf_rd_en ? word_q : 4'd0;
  assign rf_rd_vreg_a = rf_rd_en ? vs1_q  : 5'd0;
  assign rf_rd_vreg_b = rf_rd_en ? vs2_q  : 5'd0;

  // Operands are gated so the multiplier sees zeros outside valid data.
  assign mul_is_mul = p_vld[0];
  assign mul_op_A   = p_vld[0] ? rf_rd_data_a : 32'd0;
  assign mul_op_B   = p_vld[0] ? rf_rd_data_b : 32'd0;
  assign mul_sew    = sew_q;

  assign rf_wr_en   = p_vld[PD-1];
  assign rf_wr_vreg = rf_wr_en ? vd_q         : 5'd0;
  assign rf_wr_word = rf_wr_en ? p_word[PD-1] : 4'd0;
  assign rf_wr_be   = rf_wr_en ? p_be[PD-1]   : 4'd0;
  assign rf_wr_data = rf_wr_en ? mul_result   : 32'd0;

endmodule
